// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer writer: register map, FSM states
// and default geometry (80x60 pixel framebuffer, 8-bit pixels).
package fb_pkg;

  localparam int DEF_SIZE  = 13;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_DEPTH = 4800;

  // Word offsets of the Wishbone register file
  typedef enum logic [1:0] {
    REG_PTR  = 2'd0,
    REG_DATA = 2'd1,
    REG_FILL = 2'd2,   // write: start fill, read: status
    REG_LEN  = 2'd3
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/fb_ptr.sv
// Framebuffer write pointer: loadable counter that wraps at DEPTH.
// A load value outside the framebuffer clamps the pointer to 0.
module fb_ptr
  import fb_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            inc,
  output logic [SIZE-1:0] ptr
);

  localparam logic [SIZE-1:0] LAST = SIZE'(DEPTH - 1);
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);
  localparam logic [SIZE:0]   LIM  = (SIZE + 1)'(DEPTH);

  logic load_oob;

  // Flag load values beyond the last framebuffer word
  always_comb begin
    load_oob = ({1'b0, load_val} >= LIM);
  end

  // Pointer register: load wins over increment, increment wraps to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_oob ? '0 : load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ONE;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Wishbone classic slave that writes pixels into a framebuffer, either one
// at a time through the DATA register or as a hardware fill of LEN words.
module fb_writer
  import fb_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int PIX_W = DEF_PIX_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [1:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             mem_we,
  output logic [SIZE-1:0]  mem_addr,
  output logic [PIX_W-1:0] mem_data,
  output logic             busy
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  state_e           state;
  reg_sel_e         sel;
  logic [SIZE-1:0]  ptr;
  logic [SIZE-1:0]  len;
  logic [SIZE-1:0]  remain;
  logic [PIX_W-1:0] fill_val;

  logic req;
  logic accept;
  logic wr;
  logic ptr_load;
  logic data_wr;
  logic fill_start;
  logic fill_step;
  logic ptr_inc;
  logic unused_dat;

  // Request decode; writes stall while a fill is running, reads never do
  always_comb begin
    req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    sel        = reg_sel_e'(wb_adr_i);
    accept     = req & (~wb_we_i | (state == ST_IDLE));
    wr         = accept & wb_we_i;
    ptr_load   = wr & (sel == REG_PTR);
    data_wr    = wr & (sel == REG_DATA);
    fill_start = wr & (sel == REG_FILL) & (len != '0);
    fill_step  = (state == ST_FILL) & (remain != '0);
    ptr_inc    = data_wr | fill_start | fill_step;
    unused_dat = ^wb_dat_i;
  end

  fb_ptr #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (wb_dat_i[SIZE-1:0]),
    .inc      (ptr_inc),
    .ptr      (ptr)
  );

  // Bus response, register writes and the fill FSM with registered outputs.
  // The first fill word is issued on the ack edge, so remain starts at len-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      remain   <= '0;
      fill_val <= '0;
      busy     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      wb_ack_o <= accept;
      mem_we   <= 1'b0;

      if (accept && !wb_we_i) begin
        case (sel)
          REG_PTR:  wb_dat_o <= 32'(ptr);
          REG_DATA: wb_dat_o <= '0;
          REG_FILL: wb_dat_o <= {31'b0, busy};
          REG_LEN:  wb_dat_o <= 32'(len);
          default:  wb_dat_o <= '0;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (wr) begin
            case (sel)
              REG_DATA: begin
                mem_we   <= 1'b1;
                mem_addr <= ptr;
                mem_data <= wb_dat_i[PIX_W-1:0];
              end
              REG_FILL: begin
                fill_val <= wb_dat_i[PIX_W-1:0];
                if (len != '0) begin
                  state    <= ST_FILL;
                  busy     <= 1'b1;
                  remain   <= len - ONE;
                  mem_we   <= 1'b1;
                  mem_addr <= ptr;
                  mem_data <= wb_dat_i[PIX_W-1:0];
                end
              end
              REG_LEN: len <= wb_dat_i[SIZE-1:0];
              default: ;
            endcase
          end
        end
        ST_FILL: begin
          if (remain != '0) begin
            remain   <= remain - ONE;
            mem_we   <= 1'b1;
            mem_addr <= ptr;
            mem_data <= fill_val;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: a vector table of single register
// operations plus hand-written sequences for stalls, drops and reset.
module tb_fb_writer;

  localparam int SIZE  = 13;
  localparam int PIX_W = 8;
  localparam int DEPTH = 4800;

  localparam logic [1:0] A_PTR  = 2'd0;
  localparam logic [1:0] A_DATA = 2'd1;
  localparam logic [1:0] A_FILL = 2'd2;
  localparam logic [1:0] A_LEN  = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wb_cyc_i = 1'b0;
  logic             wb_stb_i = 1'b0;
  logic             wb_we_i = 1'b0;
  logic [1:0]       wb_adr_i = '0;
  logic [31:0]      wb_dat_i = '0;
  logic [31:0]      wb_dat_o;
  logic             wb_ack_o;
  logic             mem_we;
  logic [SIZE-1:0]  mem_addr;
  logic [PIX_W-1:0] mem_data;
  logic             busy;

  fb_writer #(.SIZE(SIZE), .PIX_W(PIX_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [SIZE-1:0]  a;
    logic [PIX_W-1:0] d;
    int               c;
  } wr_t;
  wr_t wq[$];

  // Record every framebuffer write with the cycle it occurred in
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back('{a: mem_addr, d: mem_data, c: cyc_cnt});
  end

  typedef struct {
    bit          we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    bit          exp_busy;
    int          nwr;
    int          a0;
    logic [7:0]  d;
  } vec_t;
  vec_t vt[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                     input logic [31:0] exp_rd, input bit exp_busy, input int nwr,
                     input int a0, input logic [7:0] d);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.exp_rd = exp_rd;
    v.exp_busy = exp_busy; v.nwr = nwr; v.a0 = a0; v.d = d;
    vt.push_back(v);
  endtask

  // One Wishbone transaction, held until ack or until limit cycles expire
  task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                     input int limit, output logic [31:0] rd, output int ack_cyc,
                     output bit ok, output bit bz);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    ok = 1'b0; ack_cyc = -1; rd = '0; bz = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o === 1'b1) begin
        ok = 1'b1; ack_cyc = cyc_cnt; rd = wb_dat_o; bz = busy;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    check({name, " idle"}, 32'(done), 32'd1);
  endtask

  task automatic op(input string name, input bit we, input logic [1:0] adr,
                    input logic [31:0] dat, input int limit, output logic [31:0] rd,
                    output int ack_cyc, output bit bz);
    bit ok;
    bus(we, adr, dat, limit, rd, ack_cyc, ok, bz);
    check({name, " ack"}, 32'(ok), 32'd1);
  endtask

  logic [31:0] rd;
  int          ac;
  int          ac2;
  bit          bz;

  initial begin
    // Vector table: {we, reg, wdata, expected read, busy at ack, #writes, first addr, pixel}
    add(0, A_PTR,  32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(0, A_LEN,  32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(0, A_FILL, 32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd10,        32'd0,   0, 0, 0,    8'h00);
    add(1, A_DATA, 32'h0000_01A5, 32'd0,   0, 1, 10,   8'hA5);
    add(1, A_DATA, 32'hFFFF_FF3C, 32'd0,   0, 1, 11,   8'h3C);
    add(0, A_PTR,  32'h0,         32'd12,  0, 0, 0,    8'h00);
    add(0, A_DATA, 32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd4799,      32'd0,   0, 0, 0,    8'h00);
    add(1, A_DATA, 32'h11,        32'd0,   0, 1, 4799, 8'h11);
    add(1, A_DATA, 32'h11,        32'd0,   0, 1, 0,    8'h11);
    add(0, A_PTR,  32'h0,         32'd1,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd100,       32'd0,   0, 0, 0,    8'h00);
    add(1, A_LEN,  32'd5,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_FILL, 32'h7F,        32'd0,   1, 5, 100,  8'h7F);
    add(0, A_PTR,  32'h0,         32'd105, 0, 0, 0,    8'h00);
    add(0, A_LEN,  32'h0,         32'd5,   0, 0, 0,    8'h00);
    add(0, A_FILL, 32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_LEN,  32'd0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_FILL, 32'h55,        32'd0,   0, 0, 0,    8'h00);
    add(0, A_FILL, 32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd5000,      32'd0,   0, 0, 0,    8'h00);
    add(0, A_PTR,  32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd4800,      32'd0,   0, 0, 0,    8'h00);
    add(0, A_PTR,  32'h0,         32'd0,   0, 0, 0,    8'h00);
    add(1, A_PTR,  32'h0001_E00A, 32'd0,   0, 0, 0,    8'h00);
    add(0, A_PTR,  32'h0,         32'd10,  0, 0, 0,    8'h00);
    add(1, A_PTR,  32'd4798,      32'd0,   0, 0, 0,    8'h00);
    add(1, A_LEN,  32'h0000_E004, 32'd0,   0, 0, 0,    8'h00);
    add(1, A_FILL, 32'h0000_0122, 32'd0,   1, 4, 4798, 8'h22);
    add(0, A_PTR,  32'h0,         32'd2,   0, 0, 0,    8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ack",      32'(wb_ack_o), 32'd0);
    check("rst mem_we",   32'(mem_we),   32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_data", 32'(mem_data), 32'd0);
    check("rst dat_o",    wb_dat_o,      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < vt.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      wq.delete();
      op(nm, vt[i].we, vt[i].adr, vt[i].dat, 50, rd, ac, bz);
      if (!vt[i].we) check({nm, " rdata"}, rd, vt[i].exp_rd);
      else           check({nm, " busy@ack"}, 32'(bz), 32'(vt[i].exp_busy));
      wait_idle(nm);
      repeat (2) @(negedge clk);
      check({nm, " nwr"}, 32'(wq.size()), 32'(vt[i].nwr));
      foreach (wq[k]) begin
        check($sformatf("%s w%0d addr", nm, k), 32'(wq[k].a), 32'((vt[i].a0 + k) % DEPTH));
        check($sformatf("%s w%0d data", nm, k), 32'(wq[k].d), 32'(vt[i].d));
        check($sformatf("%s w%0d cyc", nm, k), 32'(wq[k].c), 32'(ac + k));
      end
    end

    // Stall: status read during a 20-word fill, DATA write waits for idle
    op("A ptr", 1, A_PTR, 32'd200, 10, rd, ac, bz);
    op("A len", 1, A_LEN, 32'd20, 10, rd, ac, bz);
    wq.delete();
    op("A fill", 1, A_FILL, 32'h66, 10, rd, ac, bz);
    check("A busy@fill", 32'(bz), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    op("A status", 0, A_FILL, 32'h0, 5, rd, ac2, bz);
    check("A status rd", rd, 32'd1);
    check("A busy@issue", 32'(busy), 32'd1);
    op("A data", 1, A_DATA, 32'h99, 100, rd, ac2, bz);
    check("A busy@data ack", 32'(bz), 32'd0);
    repeat (2) @(negedge clk);
    check("A nwr", 32'(wq.size()), 32'd21);
    for (int k = 0; k < 20 && k < wq.size(); k++) begin
      check($sformatf("A f%0d addr", k), 32'(wq[k].a), 32'(200 + k));
      check($sformatf("A f%0d data", k), 32'(wq[k].d), 32'h66);
      check($sformatf("A f%0d cyc", k), 32'(wq[k].c), 32'(ac + k));
    end
    if (wq.size() == 21) begin
      check("A data addr", 32'(wq[20].a), 32'd220);
      check("A data pix",  32'(wq[20].d), 32'h99);
      check("A data cyc",  32'(wq[20].c), 32'(ac2));
      check("A data after fill", 32'(ac2 > wq[19].c), 32'd1);
    end
    op("A ptr rd", 0, A_PTR, 32'h0, 10, rd, ac, bz);
    check("A ptr val", rd, 32'd221);

    // Dropped request: DATA write presented for one stalled cycle then removed
    op("C ptr", 1, A_PTR, 32'd50, 10, rd, ac, bz);
    op("C len", 1, A_LEN, 32'd3, 10, rd, ac, bz);
    wq.delete();
    op("C fill", 1, A_FILL, 32'h12, 10, rd, ac, bz);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = A_DATA; wb_dat_i = 32'hEE;
    @(posedge clk); #1;
    check("C stalled ack", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wait_idle("C");
    repeat (3) @(negedge clk);
    check("C nwr", 32'(wq.size()), 32'd3);
    op("C ptr rd", 0, A_PTR, 32'h0, 10, rd, ac, bz);
    check("C ptr val", rd, 32'd53);

    // Reset on the 3rd cycle of a 10-word fill, with a PTR write pending
    op("B ptr", 1, A_PTR, 32'd30, 10, rd, ac, bz);
    op("B len", 1, A_LEN, 32'd10, 10, rd, ac, bz);
    wq.delete();
    op("B fill", 1, A_FILL, 32'h44, 10, rd, ac, bz);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = A_PTR; wb_dat_i = 32'd77;
    @(posedge clk); #1;
    check("B rst mem_we", 32'(mem_we),   32'd0);
    check("B rst busy",   32'(busy),     32'd0);
    check("B rst ack",    32'(wb_ack_o), 32'd0);
    check("B rst addr",   32'(mem_addr), 32'd0);
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (5) @(negedge clk);
    check("B nwr", 32'(wq.size()), 32'd3);
    op("B ptr rd", 0, A_PTR, 32'h0, 10, rd, ac, bz);
    check("B ptr val", rd, 32'd0);
    op("B len rd", 0, A_LEN, 32'h0, 10, rd, ac, bz);
    check("B len val", rd, 32'd0);
    op("B status", 0, A_FILL, 32'h0, 10, rd, ac, bz);
    check("B status val", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter SIZE, default 13: framebuffer address width.
REQ-002 Parameter PIX_W, default 8: pixel width.
REQ-003 Parameter DEPTH, default 4800: framebuffer words; DEPTH <= 2**SIZE.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave controls.
REQ-007 wb_adr_i  input  2  word register select: 0 PTR, 1 DATA, 2 FILL/STATUS, 3 LEN.
REQ-008 wb_dat_i  input  32  write data; wb_dat_o  output  32  read data; wb_ack_o  output  1  cycle acknowledge.
REQ-009 mem_we  output  1  framebuffer write strobe; mem_addr  output  SIZE  write address; mem_data  output  PIX_W  write pixel.
REQ-010 busy  output  1  fill in progress.

Function
REQ-011 Request = wb_cyc_i & wb_stb_i & !wb_ack_o; wb_ack_o is a single-cycle pulse, one cycle after an accepted request.
REQ-012 Reads are always accepted: PTR -> {0, ptr}; DATA -> 0; STATUS -> {31'b0, busy}; LEN -> {0, len}.
REQ-013 PTR write: ptr <= wb_dat_i[SIZE-1:0], or 0 if that value >= DEPTH.
REQ-014 LEN write: len <= wb_dat_i[SIZE-1:0]; no range check.
REQ-015 DATA write: at the ack edge, mem_we=1, mem_addr=ptr (pre-increment), mem_data=wb_dat_i[PIX_W-1:0]; ptr advances by one at the same edge.
REQ-016 ptr increments wrap from DEPTH-1 to 0.
REQ-017 FILL write with len=0: acked, no memory writes, state stays IDLE.
REQ-018 FILL write with len>0: acked; state goes IDLE->FILL; busy=1 from the ack cycle.
REQ-019 In FILL, mem_we=1 for exactly len consecutive cycles (first on the ack cycle); mem_data = fill value; mem_addr = ptr, ptr+1, ... (wrapping).
REQ-020 FILL->IDLE after the last write; busy drops the following cycle; final ptr = (start ptr + len) mod DEPTH; len register is preserved.
REQ-021 While busy, write requests are stalled: no ack until IDLE, then processed per REQ-013..018. Reads during FILL are acked normally.
REQ-022 mem_we=0 in every cycle not covered by REQ-015 or REQ-019; mem_addr and mem_data hold their last values.
REQ-023 Request dropped (cyc/stb deasserted) before ack: no side effect.

Reset
REQ-024 rst asserted: next edge sets state=IDLE, ptr=0, len=0, fill value=0, busy=0, wb_ack_o=0, mem_we=0, mem_addr=0, mem_data=0, wb_dat_o=0.
REQ-025 rst during FILL aborts the fill; no mem_we after the reset edge.
REQ-026 Reset takes priority over every request in the same cycle.

Structure
REQ-027 Shared package fb_pkg holds register offsets, state encodings (IDLE, FILL), and default SIZE/PIX_W/DEPTH.
REQ-028 One sub-module, fb_ptr: a pointer counter with load, increment, wrap at DEPTH, and an out-of-range load to 0. The FSM and the Wishbone decode stay in fb_writer.

Verification
REQ-029 PTR=10, DATA writes 0xA5 then 0x3C -> mem_we pulses at addr 10 (0xA5) and 11 (0x3C); PTR read returns 12.
REQ-030 PTR=4799, DATA write 0x11 twice -> writes at 4799 then 0; PTR read returns 1.
REQ-031 PTR=100, LEN=5, FILL 0x7F -> mem_we high 5 consecutive cycles at addr 100..104 with data 0x7F; busy falls afterward; PTR=105.
REQ-032 FILL active (LEN=20); issue a DATA write and a STATUS read mid-fill -> STATUS read acked with 1; DATA write acked only after busy=0, and it writes at the post-fill ptr.
REQ-033 LEN=0, FILL 0x55 -> ack only, no mem_we, busy stays 0. PTR write 5000 -> PTR read returns 0.
REQ-034 rst asserted on the 3rd cycle of a 10-word fill -> mem_we=0 from the next edge; busy=0; PTR=0.
